// File: rtl/sync_fifo_ctl_pkg.sv
// Purpose : shared constants, width helpers and read-mode enum for the sync FIFO controller.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package sync_fifo_ctl_pkg;

  // Default geometry, also used by benches so both sides agree on sizes.
  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_DEPTH     = 128;
  localparam int unsigned DEF_AF_THRESH = 124;
  localparam int unsigned DEF_AE_THRESH = 4;

  typedef enum logic {
    RD_REGISTERED = 1'b0,
    RD_FWFT       = 1'b1
  } rd_mode_e;

  // Pointer width: indexes DEPTH entries, wraps naturally at DEPTH-1 -> 0.
  function automatic int unsigned ptr_bits(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Count width: must hold the value DEPTH itself, hence depth+1.
  function automatic int unsigned cnt_bits(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic rd_mode_e rd_mode(input int unsigned fwft);
    return (fwft != 0) ? RD_FWFT : RD_REGISTERED;
  endfunction

endpackage

// File: rtl/sync_fifo_ctl_if.sv
// Purpose : request/response bundle between a FIFO user (master) and the FIFO controller (slave).
// Latency : n/a (wires only).
// Backpressure: full/empty flags tell the master when writes/reads would be rejected.
// Signals: cs, wr_en, rd_en, data_in (master -> fifo); data_out, empty, full,
//          almost_empty, almost_full, count, overflow, underflow (fifo -> master).
interface sync_fifo_ctl_if #(
  parameter int unsigned WIDTH = sync_fifo_ctl_pkg::DEF_WIDTH,
  parameter int unsigned DEPTH = sync_fifo_ctl_pkg::DEF_DEPTH
) ();
  import sync_fifo_ctl_pkg::*;

  localparam int unsigned CNT_W = cnt_bits(DEPTH);

  logic             cs;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output cs, wr_en, rd_en, data_in,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  cs, wr_en, rd_en, data_in,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ctl_mem.sv
// Purpose : WIDTH x DEPTH storage array for the FIFO controller, one write and one read port.
// Latency : write lands at the clock edge; read is combinational from the address.
// Backpressure: none; the controller only asserts we_i for accepted writes.
// Ports: clk, we_i, waddr_i, wdata_i (write side); raddr_i, rdata_o (read side).
module sync_fifo_ctl_mem
  import sync_fifo_ctl_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = ptr_bits(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  // Contents are deliberately left unreset; the controller's count guards every read.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Purpose : single-clock FIFO controller with count, almost flags, error pulses, registered or FWFT read.
// Latency : registered mode 1 cycle from rd_en to data_out; FWFT shows the head 1 cycle after a write into empty.
// Backpressure: writes rejected when full (overflow pulse), reads rejected when empty (underflow pulse).
// Ports: clk, rst (sync active-high), bus (slave side of sync_fifo_ctl_if).
module sync_fifo_ctl
  import sync_fifo_ctl_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEF_AF_THRESH,
  parameter int unsigned AE_THRESH = DEF_AE_THRESH,
  parameter int unsigned FWFT      = 0
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_ctl_if.slave bus
);

  localparam int unsigned      PTR_W   = ptr_bits(DEPTH);
  localparam int unsigned      CNT_W   = cnt_bits(DEPTH);
  localparam rd_mode_e         MODE    = rd_mode(FWFT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  // Parameter legality, caught at elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_ctl: WIDTH must be >= 1");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_ctl: DEPTH must be a power of two >= 4");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_ctl: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_ctl: AE_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT > 1) begin : g_bad_fwft
    $error("sync_fifo_ctl: FWFT must be 0 or 1");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             ovf_q,    ovf_d;
  logic             udf_q,    udf_d;
  logic [WIDTH-1:0] mem_rd;
  logic             empty_w, full_w;
  logic             wr_acc, rd_acc;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    // Accept decisions use pre-edge flags, so a simultaneous read at full
    // does not free room for the write in the same cycle (and vice versa at empty).
    wr_acc   = bus.cs & bus.wr_en & ~full_w;
    rd_acc   = bus.cs & bus.rd_en & ~empty_w;
    ovf_d    = bus.cs & bus.wr_en & full_w;
    udf_d    = bus.cs & bus.rd_en & empty_w;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      // In FWFT mode this register keeps the last popped word for display while empty.
      dout_d   = mem_rd;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sync_fifo_ctl_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.data_in),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rd)
  );

  if (MODE == RD_FWFT) begin : g_fwft
    // Head word is visible as soon as it is stored; stale popped word while empty.
    assign bus.data_out = empty_w ? dout_q : mem_rd;
  end else begin : g_registered
    assign bus.data_out = dout_q;
  end

  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  a_not_full_and_empty: assert property (@(posedge clk) disable iff (rst) !(full_w && empty_w));
  a_count_in_range:     assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);

endmodule
